// File: rtl/imem_fetch_unit_if.sv
// Fetch request / response bus of imem_fetch_unit.
// master = requester (core or bench), slave = the instruction memory.
interface imem_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_inst;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// Synchronous-read instruction memory with valid/ready fetch, configurable wait states and a load port.
// Define IMEM_PARITY_EN to store and check an even-parity bit per word (rsp_err = 11 on mismatch).
module imem_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  imem_fetch_unit_if.slave  bus,
  input  logic              ld_en,
  input  logic [ADDR_W-3:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);
  localparam int IW = ADDR_W - 2;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW:0] DEPTH_X = DEPTH[IW:0];
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [MW-1:0]     addr_q;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic              ld_ok;
  logic [MW-1:0]     req_word;
  logic [MW-1:0]     rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_err;

  assign bus.req_ready = (state == S_IDLE) && !ld_en;
  assign accept        = bus.req_valid && bus.req_ready;
  assign misaligned    = bus.req_addr[1:0] != 2'b00;
  assign out_of_range  = {1'b0, bus.req_addr[ADDR_W-1:2]} >= DEPTH_X;
  assign req_word      = bus.req_addr[MW+1:2];
  assign ld_ok         = {1'b0, ld_addr} < DEPTH_X;
  assign busy          = state != S_IDLE;

  // The read is sampled into rsp_inst on the read edge; a load on that same edge lands after it.
  assign rd_idx  = (state == S_IDLE) ? req_word : addr_q;
  assign rd_data = mem[rd_idx];

`ifdef IMEM_PARITY_EN
  logic par_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_addr[MW-1:0]]     <= ld_data;
      par_mem[ld_addr[MW-1:0]] <= ^ld_data;
    end
  end

  assign rd_err = ((^rd_data) != par_mem[rd_idx]) ? 2'b11 : 2'b00;
`else
  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_addr[MW-1:0]] <= ld_data;
    end
  end

  assign rd_err = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_inst  <= '0;
      bus.rsp_err   <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q <= req_word;
            if (misaligned || out_of_range) begin
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_inst  <= NOP;
              bus.rsp_err   <= misaligned ? 2'b01 : 2'b10;
            end else if (WAIT == 0) begin
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_inst  <= rd_data;
              bus.rsp_err   <= rd_err;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_inst  <= rd_data;
            bus.rsp_err   <= rd_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state         <= S_IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Parametrised, synchronous-read instruction memory for the RV32I core. It is the successor to the combinational instruction ROM.
- Accepts byte-addressed fetch requests over a valid/ready handshake and inserts a configurable number of wait states.
- Returns one instruction word with an error code on a valid/ready response channel.
- A separate load port writes program words, so the testbench or boot logic can fill memory without editing RTL.

Parameters:
- ADDR_W, 16: byte-address width of req_addr.
- DATA_W, 32: instruction word width.
- DEPTH, 1024: number of words. Must satisfy DEPTH <= 2^(ADDR_W-2).
- WAIT, 1: extra wait-state cycles before a valid in-range response. Range 0..15.

Ports:
- clk: in, 1. Rising-edge clock.
- rst: in, 1. Synchronous, active-high reset.
- req_valid: in, 1. Fetch request present.
- req_ready: out, 1. Block can accept a request.
- req_addr: in, ADDR_W. Byte address of the instruction.
- rsp_valid: out, 1. Response present.
- rsp_ready: in, 1. Consumer accepts the response.
- rsp_inst: out, DATA_W. Fetched instruction.
- rsp_err: out, 2. 00 ok, 01 misaligned, 10 out of range, 11 parity error.
- ld_en: in, 1. Program-load write strobe.
- ld_addr: in, ADDR_W-2. Word index for the load write.
- ld_data: in, DATA_W. Load write data.
- busy: out, 1. High in WAIT or RESP.

Behaviour:
- Reset values: state IDLE, rsp_valid 0, rsp_inst 0, rsp_err 00, busy 0. Memory contents are not reset.
- Reset mid-fetch (in WAIT or RESP) aborts the fetch and produces no response.
- req_ready is combinational: it equals (state==IDLE) && !ld_en.
- A request is accepted on the cycle req_valid && req_ready.
- State machine, IDLE:
  - On accept, latch req_addr and classify it.
  - Misaligned (req_addr[1:0] != 0) takes priority over out of range (req_addr[ADDR_W-1:2] >= DEPTH).
  - Error case: go to RESP next cycle with rsp_inst = 32'h00000013 (NOP) and the error code. No memory read.
  - OK and WAIT==0: read the memory and go to RESP.
  - OK and WAIT>0: load counter = WAIT and go to WAIT.
- State machine, WAIT: decrement the counter each cycle. On the cycle the counter reaches 1, read the memory and go to RESP.
- Latency: request accepted at edge t. rsp_valid is high from edge t+1+WAIT for an OK fetch, and from edge t+1 for an error fetch.
- State machine, RESP:
  - rsp_valid = 1. rsp_inst and rsp_err are held stable while rsp_ready = 0.
  - On rsp_valid && rsp_ready: rsp_valid drops next cycle and state returns to IDLE.
- No request is accepted in the same cycle as the response handshake. Minimum period is 2+WAIT cycles per fetch.
- Load port:
  - On an edge with ld_en = 1, write mem[ld_addr] = ld_data, in any state.
  - ld_addr >= DEPTH: the write is ignored.
  - ld_en blocks request acceptance by forcing req_ready low.
- Collision: if a load writes the same word on the same edge as the fetch read, the fetch returns the old data (read-before-write).
- A load during WAIT to the fetched word, before the read edge, is visible in the response.
- busy = (state != IDLE).

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on the load write.
  - On an OK-class read, the parity is recomputed. On mismatch, rsp_err = 11 and rsp_inst = raw read data.
  - Parity has the lowest error priority.
- Undefined: no parity storage, and rsp_err never equals 11.

Test Plan:
- Basic fetch: WAIT=2. Load mem[0]=0x00500093 and mem[1]=0x00A00113, then fetch 0x0004 with rsp_ready = 1. Required: rsp_valid rises 3 cycles after accept, rsp_inst=0x00A00113, rsp_err=00. With WAIT=0, rsp_valid rises 1 cycle after accept.
- Error fetches: fetch 0x0002, then fetch 0x1000 (word 1024, DEPTH=1024). Required: each responds 1 cycle after accept with rsp_inst=0x00000013 and rsp_err=01, then 10 respectively. No wait states for either.
- Backpressure: hold rsp_ready = 0 for 5 cycles during a fetch of 0x0000. Required: rsp_valid, rsp_inst=0x00500093 and rsp_err=00 stay stable; req_ready=0 and busy=1 throughout; return to IDLE one cycle after rsp_ready rises.
- Reset mid-fetch: assert rst during WAIT. Required: next cycle rsp_valid=0, busy=0, req_ready=1; no response is ever emitted for the aborted fetch.
- Load collision and priority: WAIT=1. Fetch 0x0000 and, on the read edge, write ld_addr=0 with 0xDEADBEEF. Required: rsp_inst=0x00500093; a refetch returns 0xDEADBEEF. Also, ld_en held high with req_valid=1 gives req_ready=0 and no accept.
- Parity (IMEM_PARITY_EN defined): force one flipped stored bit in mem[1], then fetch 0x0004. Required: rsp_err=11 with raw data returned. With the macro undefined, the same fetch returns err=00.
